// File: rtl/ex3_to_2421_serial_pkg.sv
// Shared types and constants for the excess-3 to 2421 serial converter.
package ex3_2421_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  localparam logic [3:0] EX3_MIN = 4'd3;
  localparam logic [3:0] EX3_MAX = 4'd12;
  localparam logic [3:0] OFFSET  = 4'd3;

  function automatic logic ex3_digit_legal(input logic [3:0] x);
    return (x >= EX3_MIN) && (x <= EX3_MAX);
  endfunction

endpackage

// File: rtl/ex3_to_2421_serial_if.sv
// Word-level valid/ready handshake bundle for the converter.
interface ex3_to_2421_serial_if #(
  parameter int unsigned NDIGITS = 4
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   in_ex3;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   out_2421;
  logic [NDIGITS-1:0]     out_err_mask;
  logic                   out_err;

  modport master (
    output in_valid, in_ex3, out_ready,
    input  in_ready, out_valid, out_2421, out_err_mask, out_err
  );

  modport slave (
    input  in_valid, in_ex3, out_ready,
    output in_ready, out_valid, out_2421, out_err_mask, out_err
  );

endinterface

// File: rtl/ex3_to_2421_serial_digit.sv
// Combinational single-digit excess-3 to 2421 map; illegal codes yield 0000 with err set.
module digit_ex3_to_2421
  import ex3_2421_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y,
  output logic       err
);

  always_comb begin
    y   = 4'd0;
    err = 1'b0;
    if (!ex3_digit_legal(x)) begin
      err = 1'b1;
    end else if (x < EX3_MIN + 4'd5) begin
      y = x - OFFSET;
    end else begin
      // Upper five decimal digits jump over the unused 2421 codes 0101..1010.
      y = x + OFFSET;
    end
  end

endmodule

// File: rtl/ex3_to_2421_serial.sv
// Serial excess-3 to 2421 word converter: one digit per clock, LSD first.
module ex3_to_2421_serial
  import ex3_2421_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ex3_to_2421_serial_if.slave   bus
);

  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned W    = 4 * NDIGITS;

  state_e              r_state, w_state_next;
  logic [W-1:0]        r_data, w_data_next;
  logic [W-1:0]        r_result, w_result_next;
  logic [NDIGITS-1:0]  r_err, w_err_next;
  logic [IdxW-1:0]     r_idx, w_idx_next;
  logic [3:0]          w_nibble;
  logic [3:0]          w_digit;
  logic                w_digit_err;

  assign w_nibble = r_data[4*int'(r_idx) +: 4];

  digit_ex3_to_2421 u_digit (
    .x   (w_nibble),
    .y   (w_digit),
    .err (w_digit_err)
  );

  always_comb begin
    w_state_next  = r_state;
    w_data_next   = r_data;
    w_result_next = r_result;
    w_err_next    = r_err;
    w_idx_next    = r_idx;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_data_next   = bus.in_ex3;
          w_result_next = '0;
          w_err_next    = '0;
          w_idx_next    = '0;
          w_state_next  = StConv;
        end
      end
      StConv: begin
        w_result_next[4*int'(r_idx) +: 4] = w_digit;
        w_err_next[r_idx]                 = w_digit_err;
        w_idx_next                        = r_idx + IdxW'(1);
        if (r_idx == IdxW'(NDIGITS - 1)) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_data   <= '0;
      r_result <= '0;
      r_err    <= '0;
      r_idx    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_data   <= w_data_next;
      r_result <= w_result_next;
      r_err    <= w_err_next;
      r_idx    <= w_idx_next;
    end
  end

  assign bus.in_ready     = (r_state == StIdle);
  assign bus.out_valid    = (r_state == StDone);
  assign bus.out_2421     = r_result;
  assign bus.out_err_mask = r_err;
  assign bus.out_err      = |r_err;

endmodule

// File: tb/tb_ex3_to_2421_serial.sv
// Self-checking bench for ex3_to_2421_serial: vector table, corner sequences, random words.
module tb_ex3_to_2421_serial;

  localparam int unsigned ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_q[$];

  typedef struct {
    logic [15:0] in;
    logic [15:0] exp;
    logic [3:0]  mask;
  } vec_t;

  vec_t       tbl[18];
  logic [3:0] map_tbl [16] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                               4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h0, 4'h0};

  ex3_to_2421_serial_if #(.NDIGITS(ND)) bus ();

  ex3_to_2421_serial #(.NDIGITS(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal-digit view of the code: excess-3 value minus 3, then 2421 weight.
  function automatic void model(input logic [15:0] w, output logic [15:0] r,
                                output logic [3:0] m);
    r = '0;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      int v;
      int d;
      v = int'((w >> (4 * i)) & 16'hF);
      if (v < 3 || v > 12) begin
        m[i] = 1'b1;
      end else begin
        d = v - 3;
        r[4*i +: 4] = (d < 5) ? 4'(d) : 4'(d + 6);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_word(input logic [15:0] w, input logic [15:0] er, input logic [3:0] em,
                          input int stall, input string nm);
    int lat;
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_ex3   = w;
    tick();
    bus.in_valid = 1'b0;
    bus.in_ex3   = ~w;
    wait_done(lat);
    chk({nm, " latency"}, 32'(lat), 32'(ND));
    chk({nm, " out_2421"}, 32'(bus.out_2421), 32'(er));
    chk({nm, " err_mask"}, 32'(bus.out_err_mask), 32'(em));
    chk({nm, " out_err"}, 32'(bus.out_err), 32'(|em));
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      repeat (stall) begin
        tick();
        chk({nm, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, " stall out_2421"}, 32'(bus.out_2421), 32'(er));
      end
    end
    bus.out_ready = 1'b1;
    tick();
    chk({nm, " post out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, " post in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] er;
    logic [3:0]  em;
    logic [15:0] w;
    logic [3:0]  c4;
    int          lat;

    bus.in_valid  = 1'b0;
    bus.in_ex3    = '0;
    bus.out_ready = 1'b1;

    for (int c = 0; c < 16; c++) begin
      c4          = 4'(c);
      tbl[c].in   = {4{c4}};
      tbl[c].exp  = {4{map_tbl[c]}};
      tbl[c].mask = (c < 3 || c > 12) ? 4'hF : 4'h0;
    end
    tbl[16] = '{16'h348C, 16'h01BF, 4'b0000};
    tbl[17] = '{16'h3F20, 16'h0000, 4'b0111};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_2421", 32'(bus.out_2421), 32'd0);
    chk("reset err_mask", 32'(bus.out_err_mask), 32'd0);
    chk("reset out_err", 32'(bus.out_err), 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_word(tbl[i].in, tbl[i].exp, tbl[i].mask, 0, $sformatf("vec%0d", i));
    end

    // Backpressure in DONE while a different word is offered.
    bus.in_valid = 1'b1;
    bus.in_ex3   = 16'h348C;
    tick();
    bus.in_ex3   = 16'h5678;
    wait_done(lat);
    chk("bp latency", 32'(lat), 32'(ND));
    bus.out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp out_2421", 32'(bus.out_2421), 32'h01BF);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp accept in_ready", 32'(bus.in_ready), 32'd0);
    model(16'h5678, er, em);
    wait_done(lat);
    chk("bp new latency", 32'(lat), 32'(ND));
    chk("bp new out_2421", 32'(bus.out_2421), 32'(er));
    tick();

    // Reset in the second CONV cycle aborts the word.
    bus.in_valid = 1'b1;
    bus.in_ex3   = 16'h5555;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort out_2421", 32'(bus.out_2421), 32'd0);
    chk("abort err_mask", 32'(bus.out_err_mask), 32'd0);
    chk("abort out_err", 32'(bus.out_err), 32'd0);
    run_word(16'hCCCC, 16'hFFFF, 4'h0, 0, "after abort");

    // Back-to-back words with in_valid held high.
    acc_q.delete();
    bus.in_valid = 1'b1;
    bus.in_ex3   = 16'h3333;
    tick();
    bus.in_ex3   = 16'h8888;
    wait_done(lat);
    chk("b2b first", 32'(bus.out_2421), 32'h0000);
    tick();
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
    chk("b2b second", 32'(bus.out_2421), 32'hBBBB);
    chk("b2b accept count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("b2b spacing", 32'(acc_q[1] - acc_q[0]), 32'(ND + 2));
    end
    tick();

    // Random words, mostly legal digits, random DONE stalls.
    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 9) < 7) w[4*d +: 4] = 4'($urandom_range(3, 12));
        else w[4*d +: 4] = 4'($urandom);
      end
      model(w, er, em);
      run_word(w, er, em, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
